// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package mem_access_unit_pkg;

   localparam int ADDR_W = 12;
   localparam int WORD_W = 32;

   typedef logic [ADDR_W-1:0] ram_address_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } access_size_e;

   typedef enum logic {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } mem_access_state_e;

   // Bit position of the least significant bit of a byte lane.
   function automatic int lane_bit(input logic [1:0] lane);
      return 8 * int'(lane);
   endfunction

   // Access width in bytes; the illegal encoding is treated as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SIZE_BYTE: n = 3'd1;
         SIZE_HALF: n = 3'd2;
         default:   n = 3'd4;
      endcase
      return n;
   endfunction

   function automatic word_t extend_load(input word_t raw, input logic [1:0] size,
                                         input logic is_unsigned);
      word_t result;
      case (size)
         SIZE_BYTE: result = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
         SIZE_HALF: result = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
         default:   result = raw;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Byte-lane merge for one RAM cycle: places store bytes into a word and
// pulls the same lanes out as load bytes, both aligned to a data byte offset.
module lane_merge
   import mem_access_unit_pkg::*;
(
   input  word_t      word,
   input  word_t      data,
   input  logic [1:0] first_lane,
   input  logic [2:0] byte_count,
   input  logic [1:0] data_offset,
   output word_t      merged,
   output word_t      extracted
);

   logic [2:0] lane;
   logic [2:0] src;

   // NOTE: every variable gets a default before any conditional write,
   // otherwise always_comb infers a latch for the untouched paths.
   always_comb begin
      merged    = word;
      extracted = '0;
      lane      = '0;
      src       = '0;
      for (int i = 0; i < 4; i++) begin
         lane = 3'(i);
         if (lane >= {1'b0, first_lane} && lane < {1'b0, first_lane} + byte_count) begin
            // Byte i of the RAM word pairs with byte src of the CPU-side data.
            src = lane - {1'b0, first_lane} + {1'b0, data_offset};
            merged[lane_bit(lane[1:0]) +: 8]   = data[lane_bit(src[1:0]) +: 8];
            extracted[lane_bit(src[1:0]) +: 8] = word[lane_bit(lane[1:0]) +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses to a word RAM with read-modify-write
// stores, load extension, and two-cycle handling of word-crossing accesses.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [1:0]   req_size,
   input  logic         req_unsigned,
   input  ram_address_t req_address,
   input  word_t        req_wdata,
   output logic         resp_valid,
   output word_t        resp_rdata,
   output logic         resp_fault,
   output logic         ram_write_enable,
   output ram_address_t ram_address,
   output word_t        ram_in,
   input  word_t        ram_out
);

   mem_access_state_e state_q, state_d;
   logic         resp_valid_q, resp_valid_d;
   logic         resp_fault_q, resp_fault_d;
   word_t        resp_rdata_q, resp_rdata_d;
   ram_address_t addr2_q, addr2_d;
   word_t        wdata_q, wdata_d;
   logic [1:0]   size_q, size_d;
   logic         uns_q, uns_d;
   logic         write_q, write_d;
   word_t        partial_q, partial_d;
   logic [2:0]   cnt2_q, cnt2_d;
   logic [1:0]   doff_q, doff_d;

   logic [1:0]   off;
   logic [2:0]   n_bytes;
   logic [2:0]   first_cnt;
   logic         crossing;
   logic         fault;
   logic         split;
   ram_address_t word_addr;
   logic         we;

   word_t        lm_data;
   logic [1:0]   lm_first_lane;
   logic [2:0]   lm_count;
   logic [1:0]   lm_data_off;
   word_t        merged;
   word_t        extracted;

   always_comb begin
      off       = req_address[1:0];
      n_bytes   = size_bytes(req_size);
      crossing  = ({1'b0, off} + n_bytes) > 3'd4;
      fault     = (req_size == 2'd3) || (crossing && !ALLOW_MISALIGNED);
      split     = crossing && !fault;
      first_cnt = split ? 3'd4 - {1'b0, off} : n_bytes;
      word_addr = {req_address[ADDR_W-1:2], 2'b00};
   end

   // The second RAM cycle always starts at lane 0 of the following word.
   always_comb begin
      if (state_q == SECOND) begin
         lm_data       = wdata_q;
         lm_first_lane = 2'd0;
         lm_count      = cnt2_q;
         lm_data_off   = doff_q;
      end else begin
         lm_data       = req_wdata;
         lm_first_lane = off;
         lm_count      = first_cnt;
         lm_data_off   = 2'd0;
      end
   end

   lane_merge u_lane_merge (
      .word        (ram_out),
      .data        (lm_data),
      .first_lane  (lm_first_lane),
      .byte_count  (lm_count),
      .data_offset (lm_data_off),
      .merged      (merged),
      .extracted   (extracted)
   );

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_fault_d = 1'b0;
      resp_rdata_d = '0;
      addr2_d      = addr2_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      uns_d        = uns_q;
      write_d      = write_q;
      partial_d    = partial_q;
      cnt2_d       = cnt2_q;
      doff_d       = doff_q;
      we           = 1'b0;
      ram_address  = word_addr;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (fault) begin
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else begin
                  we = req_write;
                  if (split) begin
                     state_d   = SECOND;
                     addr2_d   = word_addr + ram_address_t'(4);
                     wdata_d   = req_wdata;
                     size_d    = req_size;
                     uns_d     = req_unsigned;
                     write_d   = req_write;
                     partial_d = extracted;
                     cnt2_d    = n_bytes - first_cnt;
                     doff_d    = first_cnt[1:0];
                  end else begin
                     resp_valid_d = 1'b1;
                     resp_rdata_d = req_write ? '0
                                              : extend_load(extracted, req_size, req_unsigned);
                  end
               end
            end
         end
         SECOND: begin
            ram_address  = addr2_q;
            we           = write_q;
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_rdata_d = write_q ? '0 : extend_load(partial_q | extracted, size_q, uns_q);
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
         addr2_q      <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         write_q      <= 1'b0;
         partial_q    <= '0;
         cnt2_q       <= '0;
         doff_q       <= '0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_rdata_q <= resp_rdata_d;
         addr2_q      <= addr2_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         write_q      <= write_d;
         partial_q    <= partial_d;
         cnt2_q       <= cnt2_d;
         doff_q       <= doff_d;
      end
   end

   assign req_ready        = (state_q == IDLE);
   assign resp_valid       = resp_valid_q;
   assign resp_fault       = resp_fault_q;
   assign resp_rdata       = resp_rdata_q;
   assign ram_write_enable = we;
   assign ram_in           = we ? merged : '0;

endmodule
